multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: maximum cycles to wait for mem_ready before trapping.
REQ-002 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset); one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports instr (in, 32, instruction-register contents), mem_ready (in, 1, memory handshake done) and br_taken (in, 1, datapath branch-compare result).
REQ-004 SHALL have outputs mem_req (1, memory request), mem_we (1, store), mem_is_fetch (1, request targets instruction), ir_we (1, load instruction register) and pc_we (1, PC update).
REQ-005 SHALL have outputs pc_sel (2: 0=PC+4, 1=PC+imm, 2=ALU result), imm_sel (3: mux select), alu_src_imm (1), reg_we (1), wb_sel (2: 0=ALU, 1=mem data, 2=PC+4).
REQ-006 SHALL have outputs state_o (3, current state) and trap (1, sticky error), with err_code (2: 0=none, 1=illegal opcode, 2=memory timeout).

Function
REQ-007 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-008 FETCH: mem_req=1, mem_is_fetch=1; on mem_ready, ir_we=1 for that cycle and next state is DECODE.
REQ-009 DECODE: decode instr[6:0] and register imm_sel, alu_src_imm, wb_sel and pc_sel; the registered values hold until the next DECODE.
REQ-010 imm_sel SHALL be: LUI/AUIPC 3 (U); JAL 4 (J); JALR/LOAD 0 (I); OP-IMM 0, or 5 (I-shamt) when funct3 is 001 or 101; STORE 1 (S); BRANCH 2 (B); OP 0.
REQ-011 An opcode outside the nine listed SHALL go DECODE->TRAP with err_code=1.
REQ-012 EXEC: BRANCH asserts pc_we, with pc_sel=1 if br_taken else 0, then goes to FETCH; LOAD/STORE go to MEM; all others go to WB.
REQ-013 MEM: mem_req=1, mem_we=1 for STORE; on mem_ready, LOAD goes to WB and STORE asserts pc_we (pc_sel=0) and goes to FETCH.
REQ-014 WB: reg_we=1 and pc_we=1 for exactly one cycle; pc_sel=1 for JAL, 2 for JALR, else 0; next state FETCH.
REQ-015 Zero-wait latency SHALL be: OP/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH 3, STORE 4, LOAD 5.
REQ-016 A 4-bit wait counter SHALL clear on state entry and increment each FETCH/MEM cycle without mem_ready.
REQ-017 If the counter reaches MEM_WAIT_MAX without mem_ready, the next state SHALL be TRAP with err_code=2; mem_ready on that same cycle wins.
REQ-018 TRAP SHALL be absorbing: all strobes 0, trap=1, err_code held until rst.
REQ-019 mem_req SHALL stay asserted continuously from state entry until the mem_ready cycle inclusive; mem_ready outside FETCH/MEM SHALL be ignored.
REQ-020 ir_we, pc_we and reg_we SHALL never be asserted in the same cycle except pc_we with reg_we in WB.

Reset
REQ-021 rst SHALL force state FETCH, counter 0, imm_sel 0, pc_sel 0, wb_sel 0, alu_src_imm 0, trap 0 and err_code 0, with all strobes 0 in the reset cycle.
REQ-022 rst asserted mid-transaction, including TRAP, SHALL take priority; the first cycle after deassertion SHALL be FETCH with mem_req=1.

Structure
REQ-023 Opcode constants, the state encoding and the imm_sel/pc_sel/wb_sel encodings SHALL live in shared package rv_ctrl_pkg; imm_sel values SHALL match the immediate mux exactly.
REQ-024 Decode SHALL be a combinational sub-module ctrl_decoder (instr -> imm_sel, alu_src_imm, wb_sel, jump type, legal); the FSM, counter and registers stay in multicycle_ctrl.

Verification
REQ-025 ADDI x1,x0,5 (0x00500093), mem_ready=1 every request -> states 0,1,2,4; imm_sel=0; reg_we=1 on cycle 4 only.
REQ-026 SLLI (0x00209093) -> imm_sel=5; LUI (0x000010B7) -> imm_sel=3; JAL (0x0080006F) -> imm_sel=4 and pc_sel=1 in WB.
REQ-027 BEQ (0x00000463) with br_taken=1 -> pc_we in EXEC with pc_sel=1, next FETCH; with br_taken=0 -> pc_sel=0.
REQ-028 SW (0x00112023) with mem_ready delayed 3 cycles -> mem_we=1 held 4 cycles in MEM, then FETCH, reg_we never asserted.
REQ-029 Opcode 0x7F -> TRAP with err_code=1; mem_ready held low in FETCH for 15 cycles -> TRAP with err_code=2.
REQ-030 rst pulsed during a LOAD's MEM wait -> next cycle state_o=0, mem_req=1 and all outputs at reset values.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
//   - RV32I base opcodes recognised by the decoder
//   - FSM state encoding (also visible on state_o)
//   - Select encodings for the immediate mux, PC mux and writeback mux
//   - Internal jump / memory-operation classes produced by the decoder
//   - Trap error codes
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int OPC_COUNT = 9;
    localparam logic [OPC_COUNT-1:0][6:0] LEGAL_OPCODES = {
        OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
        OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP
    };

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Values must track the immediate generator's mux inputs one-for-one.
    typedef enum logic [2:0] {
        IMM_I       = 3'd0,
        IMM_S       = 3'd1,
        IMM_B       = 3'd2,
        IMM_U       = 3'd3,
        IMM_J       = 3'd4,
        IMM_I_SHAMT = 3'd5
    } imm_sel_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        JT_NONE   = 2'd0,
        JT_BRANCH = 2'd1,
        JT_JAL    = 2'd2,
        JT_JALR   = 2'd3
    } jump_t;

    typedef enum logic [1:0] {
        MO_NONE  = 2'd0,
        MO_LOAD  = 2'd1,
        MO_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder for the multicycle controller.
// Ports:
//   instr       - instruction register contents
//   imm_sel     - immediate format select for the immediate mux
//   alu_src_imm - ALU operand B comes from the immediate
//   wb_sel      - register writeback source
//   jump_type   - none / conditional branch / JAL / JALR
//   mem_op      - none / load / store
//   legal       - opcode is one of the nine supported base opcodes
module ctrl_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output imm_sel_t    imm_sel,
    output logic        alu_src_imm,
    output wb_sel_t     wb_sel,
    output jump_t       jump_type,
    output mem_op_t     mem_op,
    output logic        legal
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [OPC_COUNT-1:0] opc_hit;
    logic                 unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign unused_bits = ^{instr[31:15], instr[11:7]};

    genvar gi;
    generate
        for (gi = 0; gi < OPC_COUNT; gi++) begin : g_legal
            assign opc_hit[gi] = (opcode == LEGAL_OPCODES[gi]);
        end
    endgenerate

    assign legal = |opc_hit;

    always_comb begin
        imm_sel     = IMM_I;
        alu_src_imm = 1'b0;
        wb_sel      = WB_ALU;
        jump_type   = JT_NONE;
        mem_op      = MO_NONE;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                imm_sel     = IMM_U;
                alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
                imm_sel   = IMM_J;
                wb_sel    = WB_PC4;
                jump_type = JT_JAL;
            end
            OPC_JALR: begin
                alu_src_imm = 1'b1;
                wb_sel      = WB_PC4;
                jump_type   = JT_JALR;
            end
            OPC_LOAD: begin
                alu_src_imm = 1'b1;
                wb_sel      = WB_MEM;
                mem_op      = MO_LOAD;
            end
            OPC_STORE: begin
                imm_sel     = IMM_S;
                alu_src_imm = 1'b1;
                mem_op      = MO_STORE;
            end
            OPC_BRANCH: begin
                imm_sel   = IMM_B;
                jump_type = JT_BRANCH;
            end
            OPC_OP_IMM: begin
                alu_src_imm = 1'b1;
                // Shifts-by-immediate use only the 5-bit shamt field.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_sel = IMM_I_SHAMT;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   instr                     - instruction register contents
//   mem_ready                 - memory handshake complete (FETCH/MEM only)
//   br_taken                  - datapath branch compare result
//   mem_req, mem_we           - memory request / store strobe
//   mem_is_fetch              - current request is an instruction fetch
//   ir_we, pc_we, reg_we      - IR load, PC update, register-file write
//   pc_sel, imm_sel, wb_sel   - datapath mux selects
//   alu_src_imm               - ALU operand B from immediate
//   state_o                   - current FSM state
//   trap, err_code            - sticky trap flag and its cause
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_fetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state_o,
    output logic        trap,
    output logic [1:0]  err_code
);

    // Counter value on the last allowed wait cycle; a miss there times out.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

    state_t   state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    err_t     err_reg, err_next;
    imm_sel_t imm_sel_reg;
    logic     alu_src_imm_reg;
    wb_sel_t  wb_sel_reg;
    pc_sel_t  pc_sel_reg;
    jump_t    jump_reg;
    mem_op_t  mem_op_reg;

    imm_sel_t dec_imm_sel;
    logic     dec_alu_src_imm;
    wb_sel_t  dec_wb_sel;
    jump_t    dec_jump;
    mem_op_t  dec_mem_op;
    logic     dec_legal;
    pc_sel_t  dec_pc_sel;

    logic     latch_decode;
    logic     wait_timeout;
    logic     mem_req_c, mem_we_c, mem_is_fetch_c, ir_we_c, pc_we_c, reg_we_c;
    pc_sel_t  pc_sel_c;

    ctrl_decoder u_decoder (
        .instr       (instr),
        .imm_sel     (dec_imm_sel),
        .alu_src_imm (dec_alu_src_imm),
        .wb_sel      (dec_wb_sel),
        .jump_type   (dec_jump),
        .mem_op      (dec_mem_op),
        .legal       (dec_legal)
    );

    // The writeback-time PC target is known at decode; branches override it in EXEC.
    always_comb begin
        case (dec_jump)
            JT_JAL:  dec_pc_sel = PC_IMM;
            JT_JALR: dec_pc_sel = PC_ALU;
            default: dec_pc_sel = PC_PLUS4;
        endcase
    end

    assign latch_decode = (state_reg == ST_DECODE) && dec_legal;
    assign wait_timeout = !mem_ready && (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_FETCH;
            wait_cnt_reg    <= '0;
            err_reg         <= ERR_NONE;
            imm_sel_reg     <= IMM_I;
            alu_src_imm_reg <= 1'b0;
            wb_sel_reg      <= WB_ALU;
            pc_sel_reg      <= PC_PLUS4;
            jump_reg        <= JT_NONE;
            mem_op_reg      <= MO_NONE;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
            if (latch_decode) begin
                imm_sel_reg     <= dec_imm_sel;
                alu_src_imm_reg <= dec_alu_src_imm;
                wb_sel_reg      <= dec_wb_sel;
                pc_sel_reg      <= dec_pc_sel;
                jump_reg        <= dec_jump;
                mem_op_reg      <= dec_mem_op;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        err_next       = err_reg;
        wait_cnt_next  = '0;   // any state change clears the counter
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_is_fetch_c = 1'b0;
        ir_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        reg_we_c       = 1'b0;
        pc_sel_c       = pc_sel_reg;
        case (state_reg)
            ST_FETCH: begin
                mem_req_c      = 1'b1;
                mem_is_fetch_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c    = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_timeout) begin
                    state_next = ST_TRAP;
                    err_next   = ERR_TIMEOUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_TRAP;
                    err_next   = ERR_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (jump_reg == JT_BRANCH) begin
                    pc_we_c    = 1'b1;
                    pc_sel_c   = br_taken ? PC_IMM : PC_PLUS4;
                    state_next = ST_FETCH;
                end else if (mem_op_reg != MO_NONE) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (mem_op_reg == MO_STORE);
                if (mem_ready) begin
                    if (mem_op_reg == MO_STORE) begin
                        pc_we_c    = 1'b1;
                        pc_sel_c   = PC_PLUS4;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wait_timeout) begin
                    state_next = ST_TRAP;
                    err_next   = ERR_TIMEOUT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            ST_WB: begin
                reg_we_c   = 1'b1;
                pc_we_c    = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: ;   // absorbing until rst
            default: state_next = ST_FETCH;
        endcase
    end

    // Strobes are suppressed during the reset cycle itself.
    assign mem_req      = mem_req_c      & ~rst;
    assign mem_we       = mem_we_c       & ~rst;
    assign mem_is_fetch = mem_is_fetch_c & ~rst;
    assign ir_we        = ir_we_c        & ~rst;
    assign pc_we        = pc_we_c        & ~rst;
    assign reg_we       = reg_we_c       & ~rst;

    assign pc_sel      = pc_sel_c;
    assign imm_sel     = imm_sel_reg;
    assign alu_src_imm = alu_src_imm_reg;
    assign wb_sel      = wb_sel_reg;
    assign state_o     = state_reg;
    assign trap        = (state_reg == ST_TRAP);
    assign err_code    = err_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed cases followed by random
// instructions and random handshake delays, checked cycle by cycle
// against an instruction-level reference model.
module tb_multicycle_ctrl;

    localparam int WMAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_req, mem_we, mem_is_fetch, ir_we, pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic        alu_src_imm, reg_we;
    logic [1:0]  wb_sel;
    logic [2:0]  state_o;
    logic        trap;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .br_taken     (br_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_is_fetch (mem_is_fetch),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .imm_sel      (imm_sel),
        .alu_src_imm  (alu_src_imm),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .state_o      (state_o),
        .trap         (trap),
        .err_code     (err_code)
    );

    int checks = 0;
    int failures = 0;
    int txn_n = 0;

    // Architectural expectations carried between cycles by the model.
    logic [1:0] exp_err = 2'd0;
    logic [1:0] exp_pcs = 2'd0;
    logic [2:0] exp_imm = 3'd0;
    logic       exp_alu = 1'b0;
    logic [1:0] exp_wb  = 2'd0;

    typedef struct packed {
        logic       legal;
        logic       br;
        logic       ld;
        logic       st;
        logic [2:0] imm;
        logic       alu;
        logic [1:0] wb;
        logic [1:0] pcs;
    } mdl_t;

    // Instruction-level view of what each opcode requires.
    function automatic mdl_t model(input logic [31:0] ins);
        mdl_t m;
        logic [2:0] f3;
        m = '0;
        f3 = ins[14:12];
        m.legal = 1'b1;
        case (ins[6:0])
            7'h37, 7'h17: begin m.imm = 3'd3; m.alu = 1'b1; end
            7'h6F: begin m.imm = 3'd4; m.wb = 2'd2; m.pcs = 2'd1; end
            7'h67: begin m.alu = 1'b1; m.wb = 2'd2; m.pcs = 2'd2; end
            7'h03: begin m.ld = 1'b1; m.alu = 1'b1; m.wb = 2'd1; end
            7'h23: begin m.st = 1'b1; m.imm = 3'd1; m.alu = 1'b1; end
            7'h63: begin m.br = 1'b1; m.imm = 3'd2; end
            7'h13: begin
                m.alu = 1'b1;
                m.imm = (f3 == 3'b001 || f3 == 3'b101) ? 3'd5 : 3'd0;
            end
            7'h33: ;
            default: m.legal = 1'b0;
        endcase
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs already driven, check at negedge, advance.
    // stb = {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, reg_we}
    task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] stb,
                       input logic [1:0] pcs);
        @(negedge clk);
        chk({tag, "/ctl"},
            {20'd0, state_o, mem_req, mem_we, mem_is_fetch, ir_we, pc_we, reg_we, trap, err_code},
            {20'd0, st, stb, (st == 3'd5), exp_err});
        chk({tag, "/sel"},
            {24'd0, pc_sel, imm_sel, alu_src_imm, wb_sel},
            {24'd0, pcs, exp_imm, exp_alu, exp_wb});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'($urandom);
        @(negedge clk);
        chk("rst/strobes", {27'd0, mem_req, mem_we, ir_we, pc_we, reg_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 2'd0;
        exp_pcs = 2'd0;
        exp_imm = 3'd0;
        exp_alu = 1'b0;
        exp_wb  = 2'd0;
    endtask

    task automatic trap_tail();
        for (int t = 0; t < 2; t++) begin
            mem_ready = 1'($urandom);
            cyc("trap", 3'd5, 6'b000000, exp_pcs);
        end
    endtask

    // fw/mw: cycles mem_ready stays low in FETCH/MEM (>= WMAX means never).
    // rst_mem: MEM cycle index at which reset is pulsed (-1 for none).
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic brt, input int rst_mem, output string fate);
        mdl_t m;
        m = model(ins);
        instr = ins;
        br_taken = brt;
        fate = "retired";

        for (int k = 0; k <= WMAX; k++) begin
            if (k == WMAX) begin
                exp_err = 2'd2;
                trap_tail();
                do_reset();
                fate = "fetch-timeout";
                return;
            end
            mem_ready = (k == fw);
            cyc("fetch", 3'd0, {1'b1, 1'b0, 1'b1, (k == fw), 1'b0, 1'b0}, exp_pcs);
            if (k == fw) break;
        end

        mem_ready = 1'($urandom);
        cyc("decode", 3'd1, 6'b000000, exp_pcs);
        if (!m.legal) begin
            exp_err = 2'd1;
            trap_tail();
            do_reset();
            fate = "illegal";
            return;
        end
        exp_imm = m.imm;
        exp_alu = m.alu;
        exp_wb  = m.wb;
        exp_pcs = m.pcs;

        mem_ready = 1'($urandom);
        if (m.br) begin
            cyc("exec", 3'd2, 6'b000010, {1'b0, brt});
            fate = brt ? "branch-taken" : "branch-not-taken";
            return;
        end
        cyc("exec", 3'd2, 6'b000000, exp_pcs);

        if (m.ld || m.st) begin
            for (int k = 0; k <= WMAX; k++) begin
                if (k == rst_mem) begin
                    do_reset();
                    fate = "reset-in-mem";
                    return;
                end
                if (k == WMAX) begin
                    exp_err = 2'd2;
                    trap_tail();
                    do_reset();
                    fate = "mem-timeout";
                    return;
                end
                mem_ready = (k == mw);
                cyc("mem", 3'd3, {1'b1, m.st, 1'b0, 1'b0, m.st && (k == mw), 1'b0}, exp_pcs);
                if (k == mw) break;
            end
            if (m.st) begin
                fate = "store";
                return;
            end
        end

        mem_ready = 1'($urandom);
        cyc("wb", 3'd4, 6'b000011, exp_pcs);
    endtask

    task automatic txn(input logic [31:0] ins, input int fw, input int mw,
                       input logic brt, input int rst_mem);
        string fate;
        int c0;
        int f0;
        c0 = checks;
        f0 = failures;
        run_instr(ins, fw, mw, brt, rst_mem, fate);
        $display("txn %0d instr=%08h fw=%0d mw=%0d br=%0b -> %s (checks %0d, bad %0d)",
                 txn_n, ins, fw, mw, brt, fate, checks - c0, failures - f0);
        txn_n++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  opcs [9];
        logic [31:0] r;
        logic [31:0] ins;
        mdl_t        mm;
        int          sel, p, fw, mw, rm;

        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

        @(posedge clk);
        #1;
        do_reset();

        txn(32'h00500093, 0, 0, 1'b0, -1);        // ADDI: 0,1,2,4
        txn(32'h00209093, 0, 0, 1'b0, -1);        // SLLI: shamt immediate
        txn(32'h000010B7, 0, 0, 1'b0, -1);        // LUI
        txn(32'h0080006F, 0, 0, 1'b0, -1);        // JAL
        txn(32'h00000463, 0, 0, 1'b1, -1);        // BEQ taken
        txn(32'h00000463, 0, 0, 1'b0, -1);        // BEQ not taken
        txn(32'h00112023, 0, 3, 1'b0, -1);        // SW, 3-cycle memory delay
        txn(32'h0000A083, 1, 2, 1'b0, -1);        // LW with waits
        txn(32'h000080E7, 0, 0, 1'b0, -1);        // JALR
        txn(32'h0000007F, 0, 0, 1'b0, -1);        // illegal opcode
        txn(32'h00500093, WMAX, 0, 1'b0, -1);     // fetch timeout
        txn(32'h0000A083, 0, WMAX, 1'b0, -1);     // load timeout
        txn(32'h0000A083, 0, 5, 1'b0, 2);         // reset during load wait
        txn(32'h00500093, WMAX - 1, 0, 1'b0, -1); // ready on last allowed cycle
        txn(32'h00112023, 0, WMAX - 1, 1'b0, -1);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            r = $urandom();
            if (sel == 9) begin
                do begin
                    r = $urandom();
                    mm = model(r);
                end while (mm.legal);
                ins = r;
            end else begin
                ins = {r[31:7], opcs[sel]};
            end
            p  = $urandom_range(0, 19);
            fw = (p == 0) ? WMAX : (p == 1) ? WMAX - 1 : $urandom_range(0, 3);
            p  = $urandom_range(0, 19);
            mw = (p == 0) ? WMAX : (p == 1) ? WMAX - 1 : $urandom_range(0, 3);
            rm = ($urandom_range(0, 29) == 0) ? 0 : -1;
            txn(ins, fw, mw, 1'($urandom), rm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
